edge_count_monitor: RTL and testbench
=====================================

# edge_count_monitor

Downstream stage for the two-term AND-OR gate block: consumes its complementary pair `out`/`out_n`, registers both, flags any cycle where they fail to be complements, and debounces `out` into a clean level `filt`. It also emits one-cycle `rise`/`fall` pulses and counts accepted rising edges. A valid/ack snapshot port lets a slow consumer read the count without tearing.

## Interface
Parameters:
- `DEB_CYCLES`, 4, consecutive differing samples required to accept a level change (legal ≥1)
- `CNT_W`, 8, width of the rising-edge counter and snapshot

Ports:
- `clk`  in  1  single clock, all state updates on rising edge
- `areset`  in  1  asynchronous, active-high reset
- `out`  in  1  gate-stage output (same clock domain)
- `out_n`  in  1  gate-stage complement output
- `clr`  in  1  synchronous clear of `rise_cnt`, `cnt_wrap`, `pair_err`
- `snap_req`  in  1  request snapshot of `rise_cnt`
- `snap_ack`  in  1  consumer has taken `snap_data`
- `filt`  out  1  debounced level of `out`
- `rise`  out  1  one-cycle pulse on accepted 0→1 of `filt`
- `fall`  out  1  one-cycle pulse on accepted 1→0 of `filt`
- `rise_cnt`  out  CNT_W  accepted rising edges, modulo 2^CNT_W
- `cnt_wrap`  out  1  sticky: `rise_cnt` wrapped max→0
- `pair_err`  out  1  sticky: registered `out` equalled registered `out_n`
- `snap_data`  out  CNT_W  latched count
- `snap_valid`  out  1  `snap_data` held and valid

## Operation
- Capture: `in_q <= out`, `in_n_q <= out_n` every edge. Reset values: `in_q`=0, `in_n_q`=1 (no false error after reset).
- Pair check: if `in_q == in_n_q` at an edge, `pair_err` is set at that edge; stays set until `clr` or reset.
- Debounce FSM, states STABLE and PEND; counter `deb_cnt` width clog2(DEB_CYCLES+1):
  - STABLE: `in_q != filt` → PEND, `deb_cnt`=1; if DEB_CYCLES==1, instead toggle `filt` at this edge and stay STABLE.
  - PEND: `in_q == filt` → STABLE, `deb_cnt`=0 (glitch rejected, no pulse). Else `deb_cnt`+1; when the increment would reach DEB_CYCLES, toggle `filt`, `deb_cnt`=0, → STABLE.
- Edge pulses: `rise`/`fall` registered, high exactly the cycle `filt` first shows the new level.
- Counter: on the edge `filt` goes 0→1, `rise_cnt`+1; at 2^CNT_W−1 it wraps to 0 and sets `cnt_wrap` (sticky).
- `clr` priority: overrides increment and sticky sets on the same edge; `rise_cnt`=0, `cnt_wrap`=0, `pair_err`=0. Does not touch FSM, `filt`, pulses, or snapshot.
- Snapshot: when `snap_valid`=0 and `snap_req`=1, `snap_data <= rise_cnt` (pre-edge value) and `snap_valid <= 1`. While `snap_valid`=1, `snap_req` is ignored and `snap_data` is frozen. `snap_ack`=1 with `snap_valid`=1 clears `snap_valid`; `snap_ack` while invalid is ignored. Simultaneous req+ack while valid: clear only, req must be re-asserted.

## Timing
- Reset (async, immediate): FSM=STABLE, `deb_cnt`=0, all outputs 0.
- Mid-operation reset aborts any PEND count and clears a held snapshot.
- `out` changes before edge k → `in_q` at edge k → `filt`/pulse/counter update at edge k+DEB_CYCLES.
- Input pulse of `out` lasting ≥DEB_CYCLES cycles accepted; ≤DEB_CYCLES−1 cycles rejected.
- `pair_err`: input fault before edge k → `in_q`/`in_n_q` at k → `pair_err` at k+1.
- Snapshot latency: `snap_valid` rises 1 edge after `snap_req` sampled; falls 1 edge after `snap_ack` sampled. Back-to-back snapshots need one cycle with `snap_valid`=0.

## Test plan
- Reset then idle with `out`=0,`out_n`=1 for 20 cycles → all outputs 0, no `pair_err`.
- DEB_CYCLES=4: `out` high 3 cycles → no `rise`, `filt`=0; `out` high 4 cycles → `rise` single cycle 4 edges after capture, `rise_cnt`=1, later `fall` pulse.
- CNT_W=8: 256 accepted rising edges → `rise_cnt`=0, `cnt_wrap`=1; `clr` on the same edge as the 257th rise → `rise_cnt`=0, `cnt_wrap`=0.
- Drive `out`=`out_n`=1 one cycle → `pair_err`=1 two edges later, stays 1 until `clr`.
- `rise_cnt`=5, pulse `snap_req` → `snap_data`=5, `snap_valid`=1; three more rises keep `snap_data`=5; `snap_req`+`snap_ack` together → `snap_valid`=0, no new snapshot.
- Assert `areset` mid-PEND (`deb_cnt`=2) with `snap_valid`=1 → all outputs 0 immediately; after release input must re-qualify for the full DEB_CYCLES.

Source files
------------

// File: rtl/edge_count_monitor.sv
// edge_count_monitor
// Registers a complementary out/out_n pair, flags complement violations,
// debounces out into filt, emits rise/fall pulses, counts accepted rising
// edges and offers a tear-free valid/ack snapshot of that count.
module edge_count_monitor #(
    parameter int DEB_CYCLES = 4,
    parameter int CNT_W      = 8
) (
    input  logic             clk,
    input  logic             areset,
    input  logic             out,
    input  logic             out_n,
    input  logic             clr,
    input  logic             snap_req,
    input  logic             snap_ack,
    output logic             filt,
    output logic             rise,
    output logic             fall,
    output logic [CNT_W-1:0] rise_cnt,
    output logic             cnt_wrap,
    output logic             pair_err,
    output logic [CNT_W-1:0] snap_data,
    output logic             snap_valid
);

    localparam int DW = $clog2(DEB_CYCLES + 1);
    // Last PEND count before the level change is accepted.
    localparam logic [DW-1:0] DEB_LAST = DW'(DEB_CYCLES - 1);

    typedef enum logic {
        ST_STABLE = 1'b0,
        ST_PEND   = 1'b1
    } state_t;

    logic             in_q, in_n_q;
    state_t           state_q, state_d;
    logic [DW-1:0]    deb_cnt_q, deb_cnt_d;
    logic             toggle;
    logic             filt_q, filt_d;
    logic             rise_q, rise_d;
    logic             fall_q, fall_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             wrap_q, wrap_d;
    logic             perr_q, perr_d;
    logic [CNT_W-1:0] snap_data_q, snap_data_d;
    logic             snap_valid_q, snap_valid_d;

    // Input capture; in_n_q resets to 1 so the idle pair reads as valid.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            in_q   <= 1'b0;
            in_n_q <= 1'b1;
        end else begin
            in_q   <= out;
            in_n_q <= out_n;
        end
    end

    // Debounce next-state: a change must persist DEB_CYCLES samples to toggle filt.
    always_comb begin
        state_d   = state_q;
        deb_cnt_d = deb_cnt_q;
        toggle    = 1'b0;
        case (state_q)
            ST_STABLE: begin
                if (in_q != filt_q) begin
                    if (DEB_CYCLES == 1) begin
                        toggle = 1'b1;
                    end else begin
                        state_d   = ST_PEND;
                        deb_cnt_d = DW'(1);
                    end
                end
            end
            ST_PEND: begin
                if (in_q == filt_q) begin
                    state_d   = ST_STABLE;
                    deb_cnt_d = '0;
                end else if (deb_cnt_q == DEB_LAST) begin
                    toggle    = 1'b1;
                    state_d   = ST_STABLE;
                    deb_cnt_d = '0;
                end else begin
                    deb_cnt_d = deb_cnt_q + 1'b1;
                end
            end
            default: begin
                state_d   = ST_STABLE;
                deb_cnt_d = '0;
            end
        endcase
    end

    // Filtered level, edge pulses, counter, sticky flags and snapshot next-state.
    always_comb begin
        filt_d       = filt_q ^ toggle;
        rise_d       = toggle & ~filt_q;
        fall_d       = toggle & filt_q;
        cnt_d        = cnt_q;
        wrap_d       = wrap_q;
        perr_d       = perr_q;
        snap_data_d  = snap_data_q;
        snap_valid_d = snap_valid_q;

        // clr wins over both the increment and the sticky sets.
        if (clr) begin
            cnt_d  = '0;
            wrap_d = 1'b0;
            perr_d = 1'b0;
        end else begin
            if (rise_d) begin
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == {CNT_W{1'b1}}) begin
                    wrap_d = 1'b1;
                end
            end
            if (in_q == in_n_q) begin
                perr_d = 1'b1;
            end
        end

        // A held snapshot ignores further requests until acknowledged.
        if (snap_valid_q) begin
            if (snap_ack) begin
                snap_valid_d = 1'b0;
            end
        end else if (snap_req) begin
            snap_data_d  = cnt_q;
            snap_valid_d = 1'b1;
        end
    end

    // FSM state and debounce counter registers.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q   <= ST_STABLE;
            deb_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            deb_cnt_q <= deb_cnt_d;
        end
    end

    // Output-facing registers: level, pulses, counter, flags, snapshot.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            filt_q       <= 1'b0;
            rise_q       <= 1'b0;
            fall_q       <= 1'b0;
            cnt_q        <= '0;
            wrap_q       <= 1'b0;
            perr_q       <= 1'b0;
            snap_data_q  <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            filt_q       <= filt_d;
            rise_q       <= rise_d;
            fall_q       <= fall_d;
            cnt_q        <= cnt_d;
            wrap_q       <= wrap_d;
            perr_q       <= perr_d;
            snap_data_q  <= snap_data_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    assign filt       = filt_q;
    assign rise       = rise_q;
    assign fall       = fall_q;
    assign rise_cnt   = cnt_q;
    assign cnt_wrap   = wrap_q;
    assign pair_err   = perr_q;
    assign snap_data  = snap_data_q;
    assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_edge_count_monitor.sv
// Testbench for edge_count_monitor: stimulus pushes expected rise/fall/snapshot
// events into a queue; a negedge monitor pops and compares whenever the DUT
// shows a pulse or a new snapshot.
module tb_edge_count_monitor;

    localparam int DEB  = 4;
    localparam int CW   = 8;
    localparam int CMOD = 256;

    logic          clk = 1'b0;
    logic          areset = 1'b1;
    logic          out = 1'b0;
    logic          out_n = 1'b1;
    logic          clr = 1'b0;
    logic          snap_req = 1'b0;
    logic          snap_ack = 1'b0;
    logic          filt, rise, fall, cnt_wrap, pair_err, snap_valid;
    logic [CW-1:0] rise_cnt, snap_data;

    edge_count_monitor #(.DEB_CYCLES(DEB), .CNT_W(CW)) dut (
        .clk(clk), .areset(areset), .out(out), .out_n(out_n), .clr(clr),
        .snap_req(snap_req), .snap_ack(snap_ack), .filt(filt), .rise(rise),
        .fall(fall), .rise_cnt(rise_cnt), .cnt_wrap(cnt_wrap),
        .pair_err(pair_err), .snap_data(snap_data), .snap_valid(snap_valid)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int kind;   // 0 rise, 1 fall, 2 snapshot
        int cyc;
        int val;
    } ev_t;
    ev_t q[$];

    int n_tests = 0;
    int n_fail  = 0;
    int exp_cnt = 0;
    bit exp_wrap = 1'b0;
    bit sv_prev = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_rise(input int c, input bit with_clr);
        ev_t e;
        if (with_clr) begin
            exp_cnt  = 0;
            exp_wrap = 1'b0;
        end else begin
            if (exp_cnt == CMOD - 1) exp_wrap = 1'b1;
            exp_cnt = (exp_cnt + 1) % CMOD;
        end
        e.kind = 0; e.cyc = c; e.val = exp_cnt;
        q.push_back(e);
    endtask

    task automatic push_ev(input int kind, input int c, input int val);
        ev_t e;
        e.kind = kind; e.cyc = c; e.val = val;
        q.push_back(e);
    endtask

    // Drive out high for len cycles, then low; a change is accepted DEB+1
    // edges after it is driven (one capture edge plus DEB debounce edges).
    task automatic pulse(input int len);
        int c;
        c = cyc;
        out = 1'b1; out_n = 1'b0;
        if (len >= DEB) push_rise(c + DEB + 1, 1'b0);
        repeat (len) step();
        c = cyc;
        out = 1'b0; out_n = 1'b1;
        if (len >= DEB) push_ev(1, c + DEB + 1, exp_cnt);
        repeat (DEB + 2) step();
    endtask

    // Monitor: compare every pulse and every new snapshot against the queue.
    always @(negedge clk) begin
        ev_t e;
        if (rise || fall) begin
            if (q.size() == 0) begin
                check("unexpected_pulse", {30'd0, fall, rise}, 32'd0);
            end else begin
                e = q.pop_front();
                check("pulse_kind", rise ? 32'd0 : 32'd1, e.kind);
                check("pulse_cycle", cyc, e.cyc);
                check("pulse_cnt", rise_cnt, e.val);
            end
        end
        if (snap_valid && !sv_prev) begin
            if (q.size() == 0) begin
                check("unexpected_snap", 32'd1, 32'd0);
            end else begin
                e = q.pop_front();
                check("snap_kind", 32'd2, e.kind);
                check("snap_cycle", cyc, e.cyc);
                check("snap_data", snap_data, e.val);
            end
        end
        sv_prev = snap_valid;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int c;
        // Reset values
        #2;
        check("rst_filt", filt, 0);
        check("rst_rise_cnt", rise_cnt, 0);
        check("rst_snap_valid", snap_valid, 0);
        step(); step();
        areset = 1'b0;

        // Idle 20 cycles with a legal pair
        repeat (20) step();
        check("idle_filt", filt, 0);
        check("idle_pair_err", pair_err, 0);
        check("idle_rise_cnt", rise_cnt, 0);
        check("idle_wrap", cnt_wrap, 0);

        // 3-cycle pulse is rejected, 4-cycle pulse is accepted
        pulse(3);
        check("short_filt", filt, 0);
        check("short_cnt", rise_cnt, 0);
        pulse(4);
        check("long_cnt", rise_cnt, 1);
        check("long_filt_back", filt, 0);
        pulse(6);
        check("six_cnt", rise_cnt, 2);

        // Counter wrap after 256 accepted rises
        repeat (253) pulse(4);
        check("cnt_255", rise_cnt, 255);
        check("wrap_before", cnt_wrap, 0);
        pulse(4);
        check("cnt_wrapped", rise_cnt, 0);
        check("wrap_set", cnt_wrap, 1);

        // clr on the same edge as the 257th rise
        c = cyc;
        out = 1'b1; out_n = 1'b0;
        push_rise(c + DEB + 1, 1'b1);
        repeat (DEB) step();
        out = 1'b0; out_n = 1'b1; clr = 1'b1;
        push_ev(1, cyc + DEB + 1, 0);
        step();
        clr = 1'b0;
        repeat (DEB + 1) step();
        check("clr_cnt", rise_cnt, 0);
        check("clr_wrap", cnt_wrap, 0);

        // Pair fault: out=out_n=1 for one cycle
        out = 1'b1; out_n = 1'b1;
        step();
        out = 1'b0; out_n = 1'b1;
        check("perr_one_edge", pair_err, 0);
        step();
        check("perr_two_edges", pair_err, 1);
        repeat (5) step();
        check("perr_sticky", pair_err, 1);
        check("perr_no_filt", filt, 0);
        clr = 1'b1;
        step();
        clr = 1'b0;
        check("perr_cleared", pair_err, 0);

        // Snapshot hold and req+ack collision
        repeat (5) pulse(4);
        check("snap_pre_cnt", rise_cnt, 5);
        snap_req = 1'b1;
        push_ev(2, cyc + 1, 5);
        step();
        snap_req = 1'b0;
        check("snap_valid_set", snap_valid, 1);
        repeat (3) pulse(4);
        check("snap_cnt_8", rise_cnt, 8);
        snap_req = 1'b1;
        step();
        snap_req = 1'b0;
        check("snap_frozen", snap_data, 5);
        check("snap_still_valid", snap_valid, 1);
        snap_req = 1'b1; snap_ack = 1'b1;
        step();
        snap_req = 1'b0; snap_ack = 1'b0;
        check("snap_cleared", snap_valid, 0);
        step();
        check("snap_no_retake", snap_valid, 0);
        snap_ack = 1'b1;
        step();
        snap_ack = 1'b0;
        check("ack_while_invalid", snap_valid, 0);
        snap_req = 1'b1;
        push_ev(2, cyc + 1, 8);
        step();
        snap_req = 1'b0;
        check("snap2_valid", snap_valid, 1);

        // Reset mid-PEND (deb_cnt=2) with a held snapshot
        out = 1'b1; out_n = 1'b0;
        repeat (3) step();
        areset = 1'b1;
        #2;
        check("arst_filt", filt, 0);
        check("arst_cnt", rise_cnt, 0);
        check("arst_snap_valid", snap_valid, 0);
        check("arst_snap_data", snap_data, 0);
        check("arst_rise", rise, 0);
        exp_cnt  = 0;
        exp_wrap = 1'b0;
        step();
        areset = 1'b0;
        push_rise(cyc + DEB + 1, 1'b0);
        repeat (DEB + 2) step();
        check("requal_cnt", rise_cnt, 1);
        out = 1'b0; out_n = 1'b1;
        push_ev(1, cyc + DEB + 1, 1);
        repeat (DEB + 3) step();
        check("requal_filt", filt, 0);
        check("queue_drained", q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
